reg_dump: RTL and testbench

Debug register-file dumper for the single-cycle CPU. It reads the register file's debug port, which is read-only and takes an address and returns data, and sweeps the addresses from 0 to NUM_REGS-1. Each register value is formatted as a fixed-length ASCII line and streamed out over a byte valid/ready interface, for the UART or VGA text console. It sits outside the datapath and only ever drives the debug address.

---
 rtl/reg_dump_pkg.sv | 21 ++
 rtl/reg_dump_hex_ascii.sv | 17 +
 rtl/reg_dump.sv | 140 ++++++++++++++
 tb/tb_reg_dump.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared constants and FSM states for the register-file dumper
package reg_dump_pkg;

    localparam logic [7:0] ASCII_X  = 8'h78;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    localparam int LINE_LEN = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LOAD,
        ST_SEND,
        ST_NEXT,
        ST_DONE
    } dump_state_t;

endpackage

// File: rtl/reg_dump_hex_ascii.sv
// rtl/reg_dump_hex_ascii.sv - combinational nibble to uppercase ASCII hex digit
module hex_ascii
    import reg_dump_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + {4'd0, nibble};
        end else begin
            ascii = ASCII_A + {4'd0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - sweeps the register-file debug port and streams one ASCII line per register
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] debug_reg_addr,
    input  logic [DATA_W-1:0] debug_reg_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int HEX_DIGITS = DATA_W / 4;
    localparam logic [3:0] LAST_BYTE = 4'(LINE_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] snap;
    logic [3:0]        cnt;

    logic [5:0] idx6;
    logic [3:0] tens, units;
    logic [3:0] nib;
    logic [7:0] hex_char;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        tx_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                busy      = 1'b1;
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                busy      = 1'b1;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                if (tx_ready && cnt == LAST_BYTE) state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                busy      = 1'b1;
                state_nxt = (idx == LAST_IDX) ? ST_DONE : ST_ADDR;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The address is registered at the end of ADDR so LOAD gets a whole cycle of read path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx            <= '0;
            cnt            <= 4'd0;
            snap           <= '0;
            debug_reg_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) idx <= '0;
                ST_ADDR: debug_reg_addr <= idx;
                ST_LOAD: begin
                    snap <= (idx == '0) ? '0 : debug_reg_data;
                    cnt  <= 4'd0;
                end
                ST_SEND: if (tx_ready && cnt != LAST_BYTE) cnt <= cnt + 4'd1;
                ST_NEXT: if (idx != LAST_IDX) idx <= idx + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    assign idx6 = 6'(idx);

    always_comb begin
        tens  = 4'd0;
        units = idx6[3:0];
        if (idx6 >= 6'd30) begin
            tens  = 4'd3;
            units = 4'(idx6 - 6'd30);
        end else if (idx6 >= 6'd20) begin
            tens  = 4'd2;
            units = 4'(idx6 - 6'd20);
        end else if (idx6 >= 6'd10) begin
            tens  = 4'd1;
            units = 4'(idx6 - 6'd10);
        end
    end

    always_comb begin
        nib = 4'd0;
        for (int k = 0; k < HEX_DIGITS; k++) begin
            if (cnt == 4'(4 + k)) nib = snap[DATA_W-4-4*k +: 4];
        end
    end

    hex_ascii u_hex_ascii (
        .nibble (nib),
        .ascii  (hex_char)
    );

    always_comb begin
        tx_data = 8'h00;
        if (state == ST_SEND) begin
            if (cnt == 4'd0)           tx_data = ASCII_X;
            else if (cnt == 4'd1)      tx_data = ASCII_0 + {4'd0, tens};
            else if (cnt == 4'd2)      tx_data = ASCII_0 + {4'd0, units};
            else if (cnt == 4'd3)      tx_data = ASCII_EQ;
            else if (cnt == LAST_BYTE) tx_data = ASCII_LF;
            else                       tx_data = hex_char;
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// tb/tb_reg_dump.sv - randomized scoreboard bench for reg_dump
module tb_reg_dump;

    localparam int NUM_REGS   = 32;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int LINE_BYTES = 13;
    localparam int BUDGET     = 6000;

    localparam int ACT_NONE  = 0;
    localparam int ACT_START = 1;
    localparam int ACT_WRITE = 2;
    localparam int ACT_RESET = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] debug_reg_addr;
    logic [DATA_W-1:0] debug_reg_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [7:0]        exp_q [$];
    int checks = 0;
    int fails = 0;
    int total_bytes = 0;
    int total_done = 0;
    bit rand_ready = 1'b0;
    bit stall_pend = 1'b0;
    logic [7:0] stall_byte;

    always #5 clk = ~clk;

    assign debug_reg_data = regs[debug_reg_addr];

    reg_dump #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .debug_reg_addr (debug_reg_addr),
        .debug_reg_data (debug_reg_data),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: each line is just printf("x%02d=%08X\n"), address 0 reads as zero.
    task automatic push_dump();
        for (int i = 0; i < NUM_REGS; i++) begin
            logic [31:0] v;
            string s;
            v = (i == 0) ? 32'h0 : regs[i];
            s = $sformatf("x%02d=%08h\n", i, v);
            for (int k = 0; k < s.len(); k++) begin
                logic [7:0] c;
                c = s[k];
                if (c >= "a" && c <= "f") c = c - 8'd32;
                exp_q.push_back(c);
            end
        end
    endtask

    task automatic fill_regs(input int mode);
        for (int i = 0; i < NUM_REGS; i++) begin
            case (mode)
                0:       regs[i] = 32'h1000_0000 + 32'(i);
                1:       regs[i] = 32'hDEAD_BEEF;
                default: regs[i] = $urandom();
            endcase
        end
        regs[0] = $urandom() | 32'h1;
    endtask

    always @(posedge clk) begin
        #1;
        tx_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_valid_held", tx_valid, 1);
                check("stall_data_stable", tx_data, stall_byte);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL extra_byte: got %0h, expected no byte", tx_data);
                end else begin
                    check("byte", tx_data, exp_q.pop_front());
                end
                total_bytes++;
            end
            stall_pend = tx_valid && !tx_ready;
            stall_byte = tx_data;
            if (done) total_done++;
        end
    end

    task automatic run_dump(input int act, input int at_byte, input bit check_timing);
        int base_b, base_d, cyc, first_valid, done_cyc;
        bit fired, got_done;
        base_b = total_bytes;
        base_d = total_done;
        first_valid = 0;
        done_cyc = 0;
        fired = 1'b0;
        got_done = 1'b0;
        push_dump();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc <= BUDGET && !got_done) begin
            if (cyc == 1) check("busy_rise", busy, 1);
            if (tx_valid && first_valid == 0) first_valid = cyc;
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end else begin
                start = 1'b0;
                if (!fired && total_bytes - base_b >= at_byte) begin
                    fired = 1'b1;
                    if (act == ACT_START) start = 1'b1;
                    if (act == ACT_WRITE) regs[3] = 32'hCAFE_F00D;
                    if (act == ACT_RESET) begin
                        rst_n = 1'b0;
                        #1;
                        check("rst_tx_valid", tx_valid, 0);
                        check("rst_busy", busy, 0);
                        check("rst_done", done, 0);
                        check("rst_tx_data", tx_data, 0);
                        check("rst_addr", debug_reg_addr, 0);
                        @(posedge clk); @(posedge clk); #1;
                        exp_q.delete();
                        rst_n = 1'b1;
                        repeat (2) @(posedge clk);
                        #1;
                        check("after_rst_idle", tx_valid, 0);
                        return;
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        if (!got_done) begin
            checks++;
            fails++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", BUDGET);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("dump_bytes", total_bytes - base_b, NUM_REGS * LINE_BYTES);
        check("dump_done_pulses", total_done - base_d, 1);
        check("queue_drained", exp_q.size(), 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        if (check_timing) begin
            check("first_byte_latency", first_valid, 3);
            check("start_to_done", done_cyc, 3 + NUM_REGS * 16 - 2);
        end
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fill_regs(0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_valid", tx_valid, 0);
        check("reset_tx_data", tx_data, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("idle_tx_valid", tx_valid, 0);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_addr", debug_reg_addr, 0);
        end

        fill_regs(0);
        run_dump(ACT_NONE, 0, 1'b1);

        fill_regs(1);
        rand_ready = 1'b1;
        run_dump(ACT_NONE, 0, 1'b0);
        rand_ready = 1'b0;

        fill_regs(2);
        run_dump(ACT_START, 10 * LINE_BYTES, 1'b1);

        fill_regs(2);
        run_dump(ACT_WRITE, 3 * LINE_BYTES + 7, 1'b0);
        run_dump(ACT_NONE, 0, 1'b0);

        fill_regs(2);
        run_dump(ACT_RESET, 200, 1'b0);
        run_dump(ACT_NONE, 0, 1'b1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
